// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: 8259 IRR/ISR/priority owner and two-pulse INTA sequencer
module pic_inta_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_TRIGGER = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] ir_i,
  input  logic [7:0] imr_i,
  input  logic [4:0] vector_base_i,
  input  logic       aeoi_i,
  input  logic       rotate_on_eoi_i,
  input  logic       inta_n_i,
  input  logic       eoi_cmd_i,
  input  logic       eoi_specific_i,
  input  logic [2:0] eoi_level_i,
  output logic       int_out_o,
  output logic [7:0] irr_o,
  output logic [7:0] isr_o,
  output logic [1:0] inta_count_o,
  output logic [7:0] data_out_o,
  output logic       data_oe_o,
  output logic       spurious_o
);
  typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES:0][7:0] ir_q;
  logic [SYNC_STAGES:0] inta_q;
  logic [7:0] irr_q, irr_d, isr_q, isr_d, data_q, data_d, grant, ir_s, ir_set, irr_base;
  logic [2:0] lp_q, lp_d, w_q, w_d, win_l, isr_l, eoi_l;
  logic int_q, int_d, spur_q, spur_d, win_v, isr_v, inta_fall, inta_rise;
  logic grab, ack_end, eoi_ok, aeoi_ok;
  // The last chain stage is one cycle older than the synchronized value, giving the edge reference
  assign ir_s = ir_q[SYNC_STAGES-1];
  assign inta_fall = inta_q[SYNC_STAGES] & ~inta_q[SYNC_STAGES-1];
  assign inta_rise = ~inta_q[SYNC_STAGES] & inta_q[SYNC_STAGES-1];
  // Walk levels from highest to lowest priority; the winner must strictly outrank every in-service level
  always_comb begin
    logic [2:0] lvl;
    logic blocked;
    win_v = 1'b0;
    win_l = 3'd7;
    isr_v = 1'b0;
    isr_l = 3'd0;
    blocked = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lvl = lp_q + 3'd1 + 3'(k);
      blocked = blocked | isr_q[lvl];
      if (!blocked && !win_v && irr_q[lvl] && !imr_i[lvl]) begin
        win_v = 1'b1;
        win_l = lvl;
      end
      if (!isr_v && isr_q[lvl]) begin
        isr_v = 1'b1;
        isr_l = lvl;
      end
    end
  end
  // Acknowledge sequence advances on synchronized INTA edges
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = inta_fall ? ACK1 : IDLE;
      ACK1: state_d = inta_rise ? GAP : ACK1;
      GAP:  state_d = inta_fall ? ACK2 : GAP;
      default: state_d = inta_rise ? IDLE : ACK2;
    endcase
  end
  // Datapath next state: grant on first INTA, EOI sees pre-grant ISR, new IRR edges beat grant clears
  always_comb begin
    grab = (state_q == IDLE) && inta_fall;
    ack_end = (state_q == ACK2) && inta_rise;
    grant = (grab && win_v) ? (8'b1 << win_l) : 8'h00;
    eoi_l = eoi_specific_i ? eoi_level_i : isr_l;
    eoi_ok = eoi_cmd_i && (eoi_specific_i ? isr_q[eoi_level_i] : isr_v);
    aeoi_ok = ack_end && aeoi_i && !spur_q;
    isr_d = (isr_q & ~(eoi_ok ? (8'b1 << eoi_l) : 8'h00) & ~(aeoi_ok ? (8'b1 << w_q) : 8'h00)) | grant;
    lp_d = (rotate_on_eoi_i && eoi_ok) ? eoi_l : (rotate_on_eoi_i && aeoi_ok) ? w_q : lp_q;
    w_d = grab ? (win_v ? win_l : 3'd7) : w_q;
    spur_d = grab ? !win_v : ack_end ? 1'b0 : spur_q;
    data_d = ((state_q == GAP) && inta_fall) ? {vector_base_i, w_q} : data_q;
    ir_set = EDGE_TRIGGER ? (ir_s & ~ir_q[SYNC_STAGES]) : ir_s;
    irr_base = (!EDGE_TRIGGER && state_q == IDLE) ? (irr_q & ir_s) : irr_q;
    irr_d = (irr_base & ~grant) | ir_set;
    int_d = win_v && (state_d == IDLE);
  end
  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Synchronizers and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ir_q <= '0;
      inta_q <= '1;
      irr_q <= 8'h00;
      isr_q <= 8'h00;
      data_q <= 8'h00;
      lp_q <= 3'd7;
      w_q <= 3'd7;
      int_q <= 1'b0;
      spur_q <= 1'b0;
    end else begin
      ir_q <= {ir_q[SYNC_STAGES-1:0], ir_i};
      inta_q <= {inta_q[SYNC_STAGES-1:0], inta_n_i};
      irr_q <= irr_d;
      isr_q <= isr_d;
      data_q <= data_d;
      lp_q <= lp_d;
      w_q <= w_d;
      int_q <= int_d;
      spur_q <= spur_d;
    end
  end
  // Phase outputs decode straight from the state so data_oe follows reset immediately
  always_comb begin
    inta_count_o = (state_q == ACK2) ? 2'd2 : (state_q == IDLE) ? 2'd0 : 2'd1;
    data_oe_o = (state_q == ACK2);
    int_out_o = int_q;
    irr_o = irr_q;
    isr_o = isr_q;
    data_out_o = data_q;
    spurious_o = spur_q;
  end
endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- Interrupt-acknowledge controller for the 8259 PIC datapath. Owns the request register (IRR), the in-service register (ISR) and the fully-nested/rotating priority pointer.
- Raises INT toward the CPU and sequences the two-pulse INTA cycle: sets ISR on the first pulse, drives the vector on the second.
- Handles automatic EOI (AEOI), specific EOI and non-specific EOI.
- Exports inta_count so that downstream blocks can track the acknowledge phase.

Parameters:
- SYNC_STAGES, 2, depth of the synchronizer flops on ir and inta_n (minimum 2).
- EDGE_TRIGGER, 1, 1 = IRR latches on rising edges of ir; 0 = level-triggered.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ir  in  8  raw interrupt request lines, asynchronous
- imr  in  8  interrupt mask; 1 = masked
- vector_base  in  5  vector bits T7..T3 (ICW2)
- aeoi  in  1  automatic-EOI mode enable
- rotate_on_eoi  in  1  rotate priority on every EOI
- inta_n  in  1  CPU acknowledge strobe, active-low, asynchronous
- eoi_cmd  in  1  one-cycle EOI command pulse
- eoi_specific  in  1  qualifies eoi_cmd; 1 = specific EOI
- eoi_level  in  3  IR level used by a specific EOI
- int_out  out  1  interrupt request to the CPU
- irr  out  8  interrupt request register
- isr  out  8  in-service register
- inta_count  out  2  acknowledge phase: 0 idle, 1 first pulse seen, 2 second pulse seen
- data_out  out  8  vector byte
- data_oe  out  1  data_out is valid and driven
- spurious  out  1  the current acknowledge cycle found no valid request

Behaviour:
- Reset values:
  - irr, isr, data_out, inta_count: 0
  - int_out, data_oe, spurious: 0
  - lowest-priority pointer lp = 7, so IR0 has highest priority
  - FSM state = IDLE
- Synchronization: ir and inta_n each pass through SYNC_STAGES flops. Edges of inta_n are detected on the synchronized value.
- IRR set:
  - Edge mode: bit set on a 0->1 transition of the synchronized ir.
  - Level mode: bit set while the synchronized ir is 1, and cleared when it is 0 outside an acknowledge cycle.
- IRR clear: a bit is cleared only when it is granted at the first INTA.
- Priority: the candidate set is irr & ~imr. Priority order starts at level (lp+1) mod 8 and wraps around.
- Winner: the highest-priority candidate that outranks every set isr bit (fully nested mode).
- int_out: registered; equals "a winner exists" one cycle later, and is held at 0 whenever state != IDLE.
- FSM:
  - IDLE: on an inta falling edge, latch the winner level W.
    - If a winner exists: set isr[W] and clear irr[W].
    - If no winner: W = 7, spurious = 1, isr unchanged.
    - Then go to ACK1 with inta_count = 1.
  - ACK1: on an inta rising edge, go to GAP.
  - GAP: on an inta falling edge, go to ACK2 with inta_count = 2, data_out = {vector_base, W}, data_oe = 1.
  - ACK2: on an inta rising edge:
    - data_oe = 0.
    - If aeoi=1 and spurious=0: clear isr[W]; if rotate_on_eoi=1, also set lp = W.
    - Go to IDLE with inta_count = 0 and spurious = 0.
- EOI, on an eoi_cmd pulse:
  - Specific: clear isr[eoi_level].
  - Non-specific: clear the highest-priority set isr bit under the current lp ordering.
  - If rotate_on_eoi=1, set lp to the cleared level.
  - If isr = 0, or the specific bit is already 0: no change, and lp is unchanged.
- Simultaneous events:
  - eoi_cmd in the same cycle as the first-INTA ISR set: the EOI evaluates the pre-update isr, then the new bit is set.
  - An IRR set and an IRR clear of the same bit in the same cycle: the set wins (the new edge is kept pending).
- Masking: changing imr never alters irr or isr; it only affects arbitration.
- Reset mid-cycle: all state returns to reset values immediately and data_oe drops asynchronously.

Test Plan:
- ir[3] 0->1, all unmasked, lp = 7 -> irr = 0x08 after SYNC_STAGES+1 cycles, int_out = 1 one cycle later. Two INTA pulses -> isr = 0x08, irr = 0x00, inta_count 1 then 2, data_out = {vector_base, 3'd3}.
- ir[5] and ir[1] rise together -> IR1 is serviced first (isr = 0x02). A non-specific EOI gives isr = 0; int_out reasserts and IR5 is serviced next.
- IR2 in service, then ir[6] pulses -> int_out stays 0 (nested). ir[0] pulses -> int_out = 1 and isr becomes 0x05 after the INTA cycle.
- Run an INTA cycle with irr & ~imr = 0 -> spurious = 1, data_out = {vector_base, 3'd7}, isr unchanged.
- aeoi = 1, rotate_on_eoi = 1, service IR4 -> isr = 0 at the end of ACK2, lp = 4, IR5 becomes highest priority. Then ir[0] and ir[5] pending -> IR5 is serviced first.
- Assert reset while in GAP with isr = 0x10 -> isr = 0, inta_count = 0, data_oe = 0 immediately. After release, state = IDLE and lp = 7.
